// File: rtl/prog_mem.sv
// prog_mem: synchronous program RAM with a reset/reinit-triggered init sequencer
// that fills it with zeros or the CDEC demo program before accepting CPU accesses.
module prog_mem #(
   parameter int ADRS_W    = 8,
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 256,
   parameter int INIT_MODE = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADRS_W-1:0] adrs,
   input  logic [DATA_W-1:0] data,
   input  logic              wr_en,
   input  logic              reinit,
   output logic [DATA_W-1:0] q,
   output logic              ready
);
   localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [ADRS_W:0] DEPTH_L = (ADRS_W + 1)'(DEPTH);

   typedef enum logic {INIT, READY} state_t;

   state_t             state;
   logic [PTR_W-1:0]   init_ptr;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic               in_range;

   function automatic logic [DATA_W-1:0] init_word(input logic [PTR_W-1:0] a);
      logic [7:0] b;
      case (32'(a))
         0:       b = 8'h81;
         1:       b = 8'h07;
         2:       b = 8'h06;
         3:       b = 8'h22;
         4:       b = 8'h41;
         5:       b = 8'hC0;
         6:       b = 8'h05;
         7:       b = 8'h03;
         default: b = 8'h00;
      endcase
      return INIT_MODE == 1 ? DATA_W'(b) : '0;
   endfunction

   assign in_range = {1'b0, adrs} < DEPTH_L;

   // The array has no reset; the init sequence overwrites every word instead.
   always_ff @(posedge clock)
      if (state == INIT) mem[init_ptr] <= init_word(init_ptr);
      else if (wr_en && !reinit && in_range) mem[adrs] <= data;

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state    <= INIT;
         init_ptr <= '0;
         q        <= '0;
         ready    <= 1'b0;
      end else if (state == INIT) begin
         q        <= '0;
         init_ptr <= init_ptr + 1'b1;
         if (init_ptr == PTR_W'(DEPTH - 1)) begin
            state    <= READY;
            ready    <= 1'b1;
            init_ptr <= '0;
         end
      end else if (reinit) begin
         state    <= INIT;
         init_ptr <= '0;
         ready    <= 1'b0;
         q        <= '0;
      end else begin
         q <= !in_range ? '0 : wr_en ? data : mem[adrs];
      end
endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: vector table plus randomized traffic against a behavioural model,
// covering a default build and a DEPTH=200 zero-fill build side by side.
module tb_prog_mem;
   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] adrs, data;
   logic       wr_en, reinit;
   logic [7:0] q, q2;
   logic       ready, ready2;

   int errors = 0;
   int checks = 0;

   logic [7:0] demo [8] = '{8'h81, 8'h07, 8'h06, 8'h22, 8'h41, 8'hC0, 8'h05, 8'h03};
   int         dep  [2] = '{256, 200};
   int         mode [2] = '{1, 0};
   logic [7:0] mm   [2][256];
   int         cnt  [2];
   bit         rr   [2];
   logic [7:0] qq   [2];

   typedef struct {
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp_q;
   } vec_t;
   vec_t vecs [9];

   always #5 clock = ~clock;

   prog_mem dut (
      .clock(clock), .reset_n(reset_n), .adrs(adrs), .data(data),
      .wr_en(wr_en), .reinit(reinit), .q(q), .ready(ready)
   );

   prog_mem #(.DEPTH(200), .INIT_MODE(0)) dut2 (
      .clock(clock), .reset_n(reset_n), .adrs(adrs), .data(data),
      .wr_en(wr_en), .reinit(reinit), .q(q2), .ready(ready2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0;
         rr[i]  = 1'b0;
         qq[i]  = 8'h00;
      end
   endtask

   // One clock: drive, advance both models by the behavioural rules, compare.
   task automatic cyc(input logic w, input logic [7:0] a, input logic [7:0] d, input logic ri);
      wr_en = w; adrs = a; data = d; reinit = ri;
      @(posedge clock);
      for (int i = 0; i < 2; i++) begin
         if (!rr[i]) begin
            cnt[i]++;
            qq[i] = 8'h00;
            if (cnt[i] == dep[i]) begin
               rr[i] = 1'b1;
               for (int k = 0; k < 256; k++)
                  mm[i][k] = (mode[i] == 1 && k < 8) ? demo[k % 8] : 8'h00;
            end
         end else if (ri) begin
            rr[i] = 1'b0; cnt[i] = 0; qq[i] = 8'h00;
         end else if (int'(a) >= dep[i]) qq[i] = 8'h00;
         else if (w) begin
            mm[i][a] = d; qq[i] = d;
         end else qq[i] = mm[i][a];
      end
      #1;
      check("model_q", 32'(q), 32'(qq[0]));
      check("model_ready", 32'(ready), 32'(rr[0]));
      check("model_q2", 32'(q2), 32'(qq[1]));
      check("model_ready2", 32'(ready2), 32'(rr[1]));
   endtask

   task automatic run_init(input int pulse_at);
      for (int e = 1; e <= 256; e++) begin
         cyc(1'b0, 8'($urandom), 8'($urandom), e == pulse_at);
         check("init_ready", 32'(ready), 32'(e == 256));
         check("init_q", 32'(q), 32'h0);
         check("init_ready2", 32'(ready2), 32'(e >= 200));
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      check("rst_q", 32'(q), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_ready2", 32'(ready2), 32'h0);
      @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h81};
      vecs[1] = '{1'b0, 8'h05, 8'h00, 8'hC0};
      vecs[2] = '{1'b0, 8'h07, 8'h00, 8'h03};
      vecs[3] = '{1'b0, 8'h08, 8'h00, 8'h00};
      vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h00};
      vecs[5] = '{1'b1, 8'h10, 8'hA5, 8'hA5};
      vecs[6] = '{1'b0, 8'h10, 8'h00, 8'hA5};
      vecs[7] = '{1'b1, 8'h11, 8'h5A, 8'h5A};
      vecs[8] = '{1'b0, 8'h11, 8'h00, 8'h5A};

      reset_n = 1'b0; wr_en = 1'b0; reinit = 1'b0; adrs = 8'h00; data = 8'h00;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check("reset_q", 32'(q), 32'h0);
      check("reset_ready", 32'(ready), 32'h0);
      reset_n = 1'b1;
      run_init(0);

      foreach (vecs[i]) begin
         cyc(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0);
         check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      end

      cyc(1'b0, 8'h00, 8'h00, 1'b0);
      check("d200_read0", 32'(q2), 32'h00);
      cyc(1'b1, 8'hF0, 8'h12, 1'b0);
      cyc(1'b0, 8'hF0, 8'h00, 1'b0);
      check("d200_oor_read", 32'(q2), 32'h00);
      cyc(1'b1, 8'hC7, 8'h12, 1'b0);
      cyc(1'b0, 8'hC7, 8'h00, 1'b0);
      check("d200_last_word", 32'(q2), 32'h12);

      for (int n = 0; n < 300; n++)
         cyc($urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom), 1'b0);

      cyc(1'b1, 8'h20, 8'h77, 1'b1);
      check("reinit_ready", 32'(ready), 32'h0);
      check("reinit_q", 32'(q), 32'h0);
      run_init(50);
      cyc(1'b0, 8'h10, 8'h00, 1'b0);
      check("reinit_rd10", 32'(q), 32'h00);
      cyc(1'b0, 8'h20, 8'h00, 1'b0);
      check("reinit_rd20", 32'(q), 32'h00);
      cyc(1'b0, 8'h00, 8'h00, 1'b0);
      check("reinit_rd00", 32'(q), 32'h81);

      pulse_reset();
      for (int e = 1; e <= 100; e++) begin
         cyc(1'b1, 8'($urandom), 8'($urandom), 1'b0);
         check("pre_rst_ready", 32'(ready), 32'h0);
      end
      pulse_reset();
      run_init(0);
      cyc(1'b0, 8'h00, 8'h00, 1'b0);
      check("final_rd00", 32'(q), 32'h81);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
